pong_match_ctrl: RTL and testbench

//  Match sequencer for the pong ball/paddle core. It gates the core's motion with a
//  one-cycle step enable, recentres the core with a one-cycle reset pulse, detects

---
 rtl/pong_pkg.sv | 16 +
 rtl/pong_match_ctrl_if.sv | 28 ++
 rtl/pong_step_div.sv | 39 +++
 rtl/pong_match_ctrl.sv | 129 ++++++++++++
 tb/tb_pong_match_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong core and its match sequencer.
// State encoding and playfield geometry.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int WIDTH       = 80;
    localparam int HEIGHT      = 40;
    localparam int PADDLE_SIZE = 6;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between frame source / pong core and the match sequencer.
// master drives the inputs of the sequencer, slave is the sequencer itself.
interface pong_match_ctrl_if;

    logic       start;
    logic       frame_tick;
    logic [6:0] ball_x;
    logic       core_step;
    logic       core_rst;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;
    logic [1:0] state;

    modport master (
        output start, frame_tick, ball_x,
        input  core_step, core_rst, score1, score2,
        input  game_over, winner, state
    );

    modport slave (
        input  start, frame_tick, ball_x,
        output core_step, core_rst, score1, score2,
        output game_over, winner, state
    );

endinterface

// File: rtl/pong_step_div.sv
// frame_tick divider: one registered step pulse every SPEED_DIV enabled ticks.
// i_clr restarts the count so each serve begins from a fresh phase.
module pong_step_div #(
    parameter int SPEED_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_tick,
    output logic o_step
);

    localparam int CW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPEED_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_step;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (i_en && i_tick) begin
                if (r_cnt == LAST) begin
                    r_cnt  <= '0;
                    r_step <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve delay, motion gating, miss detection and scoring.
// All outputs come straight from registers.
module pong_match_ctrl #(
    parameter int WIDTH       = pong_pkg::WIDTH,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 30,
    parameter int SPEED_DIV   = 2
) (
    input logic              clk,
    input logic              reset,
    pong_match_ctrl_if.slave bus
);

    import pong_pkg::*;

    localparam int DW = $clog2(SERVE_DELAY + 1);
    localparam logic [DW-1:0] DLY = DW'(SERVE_DELAY);
    localparam logic [3:0]    WIN = 4'(WIN_SCORE);

    state_t        r_state;
    logic [DW-1:0] r_delay;
    logic [3:0]    r_score1;
    logic [3:0]    r_score2;
    logic          r_rst;
    logic          r_go;
    logic          r_win;
    logic          r_start_q;

    logic       w_start_edge;
    logic       w_in_play;
    logic       w_miss_l;
    logic       w_miss_r;
    logic       w_step_en;
    logic       w_step;
    logic [3:0] w_inc1;
    logic [3:0] w_inc2;

    assign w_start_edge = bus.start & ~r_start_q;
    assign w_in_play    = (r_state == PLAY);
    assign w_miss_l     = w_in_play && (bus.ball_x == 7'd0);
    assign w_miss_r     = w_in_play && (bus.ball_x == 7'(WIDTH - 1));
    assign w_inc1       = r_score1 + 4'd1;
    assign w_inc2       = r_score2 + 4'd1;

    // a miss swallows any tick in the same cycle
    assign w_step_en = w_in_play && !w_miss_l && !w_miss_r;

    pong_step_div #(
        .SPEED_DIV (SPEED_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (!w_in_play),
        .i_en   (w_step_en),
        .i_tick (bus.frame_tick),
        .o_step (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_delay   <= '0;
            r_score1  <= 4'd0;
            r_score2  <= 4'd0;
            r_rst     <= 1'b0;
            r_go      <= 1'b0;
            r_win     <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            r_rst     <= 1'b0;
            case (r_state)
                IDLE, OVER: begin
                    if (w_start_edge) begin
                        r_score1 <= 4'd0;
                        r_score2 <= 4'd0;
                        r_go     <= 1'b0;
                        r_win    <= 1'b0;
                        r_rst    <= 1'b1;
                        r_delay  <= DLY;
                        r_state  <= SERVE;
                    end
                end
                SERVE: begin
                    if (bus.frame_tick) begin
                        r_delay <= r_delay - 1'b1;
                        if (r_delay == DW'(1))
                            r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_miss_l) begin
                        r_score2 <= w_inc2;
                        if (w_inc2 == WIN) begin
                            r_state <= OVER;
                            r_go    <= 1'b1;
                            r_win   <= 1'b1;
                        end else begin
                            r_rst   <= 1'b1;
                            r_delay <= DLY;
                            r_state <= SERVE;
                        end
                    end else if (w_miss_r) begin
                        r_score1 <= w_inc1;
                        if (w_inc1 == WIN) begin
                            r_state <= OVER;
                            r_go    <= 1'b1;
                            r_win   <= 1'b0;
                        end else begin
                            r_rst   <= 1'b1;
                            r_delay <= DLY;
                            r_state <= SERVE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.core_step = w_step;
    assign bus.core_rst  = r_rst;
    assign bus.score1    = r_score1;
    assign bus.score2    = r_score2;
    assign bus.game_over = r_go;
    assign bus.winner    = r_win;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE=3, SERVE_DELAY=3, SPEED_DIV=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pong_match_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   n_step;
    int   n_rst;

    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .WIDTH       (80),
        .WIN_SCORE   (3),
        .SERVE_DELAY (3),
        .SPEED_DIV   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        n_step += int'(bus.core_step);
        n_rst  += int'(bus.core_rst);
        if (bus.core_step) begin
            chk("step_in_play", int'(bus.state), 2);
            chk("step_rst_excl", int'(bus.core_rst), 0);
        end
        if (bus.score1 > 4'd3 || bus.score2 > 4'd3)
            chk("score_cap", int'(bus.score1 + bus.score2), 3);
    endtask

    task automatic ftick();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        cyc();
    endtask

    task automatic serve();
        repeat (3) ftick();
    endtask

    task automatic miss(input logic [6:0] x);
        bus.ball_x = x;
        cyc();
        bus.ball_x = 7'd40;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_step = 0;
        n_rst = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.frame_tick = 1'b0;
        bus.ball_x = 7'd40;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_s1", int'(bus.score1), 0);
        chk("rst_s2", int'(bus.score2), 0);
        chk("rst_step", int'(bus.core_step), 0);
        chk("rst_crst", int'(bus.core_rst), 0);
        chk("rst_go", int'(bus.game_over), 0);
        chk("rst_win", int'(bus.winner), 0);

        // 1: start edge, serve delay
        n_step = 0;
        bus.start = 1'b1;
        cyc();
        chk("t1_crst", int'(bus.core_rst), 1);
        chk("t1_serve", int'(bus.state), 1);
        cyc();
        chk("t1_crst_end", int'(bus.core_rst), 0);
        ftick();
        ftick();
        chk("t1_still_serve", int'(bus.state), 1);
        ftick();
        chk("t1_play", int'(bus.state), 2);
        chk("t1_no_step", n_step, 0);

        // 2: divided stepping
        n_step = 0;
        n_rst = 0;
        for (int i = 0; i < 4; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
            chk("t2_step", int'(bus.core_step), i % 2);
            cyc();
        end
        chk("t2_nstep", n_step, 2);
        chk("t2_nrst", n_rst, 0);

        // 3: left wall miss, held ball
        bus.ball_x = 7'd0;
        cyc();
        chk("t3_s2", int'(bus.score2), 1);
        chk("t3_crst", int'(bus.core_rst), 1);
        chk("t3_serve", int'(bus.state), 1);
        n_rst = 0;
        repeat (5) cyc();
        chk("t3_hold_s2", int'(bus.score2), 1);
        chk("t3_hold_rst", n_rst, 0);
        bus.ball_x = 7'd40;

        // 4: miss coincides with div-completing tick
        serve();
        chk("t4_play", int'(bus.state), 2);
        ftick();
        n_step = 0;
        bus.ball_x = 7'd79;
        bus.frame_tick = 1'b1;
        cyc();
        chk("t4_s1", int'(bus.score1), 1);
        chk("t4_serve", int'(bus.state), 1);
        chk("t4_crst", int'(bus.core_rst), 1);
        chk("t4_step", int'(bus.core_step), 0);
        bus.frame_tick = 1'b0;
        bus.ball_x = 7'd40;
        cyc();
        cyc();
        chk("t4_nstep", n_step, 0);

        // 5: player 1 wins, restart
        serve();
        miss(7'd79);
        chk("t5_s1_2", int'(bus.score1), 2);
        serve();
        bus.ball_x = 7'd79;
        cyc();
        chk("t5_over", int'(bus.state), 3);
        chk("t5_go", int'(bus.game_over), 1);
        chk("t5_win", int'(bus.winner), 0);
        chk("t5_s1_3", int'(bus.score1), 3);
        chk("t5_no_crst", int'(bus.core_rst), 0);
        n_rst = 0;
        repeat (3) cyc();
        chk("t5_hold_s1", int'(bus.score1), 3);
        chk("t5_hold_rst", n_rst, 0);
        bus.ball_x = 7'd40;
        bus.start = 1'b0;
        cyc();
        bus.start = 1'b1;
        cyc();
        chk("t5_re_state", int'(bus.state), 1);
        chk("t5_re_s1", int'(bus.score1), 0);
        chk("t5_re_s2", int'(bus.score2), 0);
        chk("t5_re_go", int'(bus.game_over), 0);
        chk("t5_re_crst", int'(bus.core_rst), 1);
        n_rst = 0;
        repeat (4) cyc();
        chk("t5_no_second", n_rst, 0);
        chk("t5_still_serve", int'(bus.state), 1);

        // 6: reset mid-play
        serve();
        miss(7'd79);
        serve();
        miss(7'd79);
        serve();
        chk("t6_s1", int'(bus.score1), 2);
        chk("t6_play", int'(bus.state), 2);
        ftick();
        bus.start = 1'b0;
        n_step = 0;
        n_rst = 0;
        reset = 1'b1;
        bus.frame_tick = 1'b1;
        cyc();
        chk("t6_idle", int'(bus.state), 0);
        chk("t6_s1_0", int'(bus.score1), 0);
        chk("t6_s2_0", int'(bus.score2), 0);
        bus.frame_tick = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t6_nstep", n_step, 0);
        chk("t6_nrst", n_rst, 0);
        chk("t6_stay_idle", int'(bus.state), 0);

        // 7: player 2 wins
        bus.start = 1'b1;
        cyc();
        serve();
        miss(7'd0);
        serve();
        miss(7'd0);
        serve();
        miss(7'd0);
        chk("t7_over", int'(bus.state), 3);
        chk("t7_win", int'(bus.winner), 1);
        chk("t7_s2", int'(bus.score2), 3);
        chk("t7_s1", int'(bus.score1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
